// File: rtl/pc_defs_pkg.sv
// Shared definitions for the fetch-stage program-counter generator.
package pc_defs;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int INSTR_BYTES    = 4;

    // Source that supplies the next fetch PC, listed lowest to highest priority.
    typedef enum logic [2:0] {
        SRC_SEQ,
        SRC_HOLD,
        SRC_RAS,
        SRC_JUMP,
        SRC_BR
    } next_src_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular storage with a top pointer and a saturating
// occupancy count. A push onto a full stack overwrites the oldest entry.
module pc_ras import pc_defs::*; #(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = 8,
    parameter bit FLUSH_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  squash,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    output logic [ADDR_WIDTH-1:0] top_addr,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      ptr;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  pop_hit;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(DEPTH));
    assign pop_hit  = pop && !empty;
    assign top_addr = mem[ptr];

    // Entry write: a push alongside a successful pop replaces the top in place,
    // otherwise it lands one slot above the current top.
    // NOTE: the storage array has no reset; count alone decides which entries are
    // live, so stale contents are never observed and the array stays a plain RAM.
    always_ff @(posedge clk) begin
        if (!rst && !squash && push) begin
            if (pop_hit) begin
                mem[ptr] <= push_addr;
            end else begin
                mem[ptr + PTR_W'(1)] <= push_addr;
            end
        end
    end

    // Pointer, count and one-cycle overflow/underflow pulses. Decoder operations
    // that coincide with a branch redirect are wrong-path and leave the stack alone.
    // NOTE: sequential state is assigned with <= so every register samples the
    // pre-edge values, independent of statement order in the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
            if (squash) begin
                if (FLUSH_EN) begin
                    count <= '0;
                end
            end else begin
                if (pop && empty) begin
                    underflow <= 1'b1;
                end
                if (push && !pop_hit) begin
                    ptr <= ptr + PTR_W'(1);
                    if (full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end else if (pop_hit && !push) begin
                    ptr   <= ptr - PTR_W'(1);
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch program-counter generator: registered fetch PC chosen each cycle from
// branch redirect, decoder jump, return-address pop or sequential advance.
module pc_gen import pc_defs::*; #(
    parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int                    FETCH_WIDTH = 1,
    parameter int                    RAS_DEPTH   = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter bit                    RAS_FLUSH   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_stall,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  pc_valid,
    input  logic [ADDR_WIDTH-1:0] dec_pc,
    input  logic                  dec_jump_valid,
    input  logic [ADDR_WIDTH-1:0] dec_jump_offset,
    input  logic                  dec_call,
    input  logic                  dec_ret,
    input  logic                  br_redirect_valid,
    input  logic [ADDR_WIDTH-1:0] br_target,
    output logic                  ras_overflow,
    output logic                  ras_underflow
);

    localparam logic [ADDR_WIDTH-1:0] SEQ_STEP   = ADDR_WIDTH'(INSTR_BYTES * FETCH_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] RET_STEP   = ADDR_WIDTH'(INSTR_BYTES);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(INSTR_BYTES - 1);

    next_src_e             src;
    logic [ADDR_WIDTH-1:0] next_pc;
    logic [ADDR_WIDTH-1:0] ras_top;
    logic                  ras_empty;

    pc_ras #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (RAS_DEPTH),
        .FLUSH_EN   (RAS_FLUSH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (dec_call),
        .pop       (dec_ret),
        .squash    (br_redirect_valid),
        .push_addr (dec_pc + RET_STEP),
        .top_addr  (ras_top),
        .empty     (ras_empty),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    // Priority select: redirects beat stall; a return with an empty stack falls through.
    // NOTE: every combinational output gets a default first, so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        src = SRC_SEQ;
        if (br_redirect_valid) begin
            src = SRC_BR;
        end else if (dec_jump_valid) begin
            src = SRC_JUMP;
        end else if (dec_ret && !ras_empty) begin
            src = SRC_RAS;
        end else if (pc_stall) begin
            src = SRC_HOLD;
        end
    end

    // Next-PC value for the selected source; targets are word aligned, adds wrap.
    always_comb begin
        next_pc = pc + SEQ_STEP;
        case (src)
            SRC_BR:   next_pc = br_target & ALIGN_MASK;
            SRC_JUMP: next_pc = (dec_pc + dec_jump_offset) & ALIGN_MASK;
            SRC_RAS:  next_pc = ras_top & ALIGN_MASK;
            SRC_HOLD: next_pc = pc;
            default:  next_pc = pc + SEQ_STEP;
        endcase
    end

    // Fetch PC register: the reset vector is held for the first valid cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC;
            pc_valid <= 1'b0;
        end else if (!pc_valid) begin
            pc_valid <= 1'b1;
        end else begin
            pc <= next_pc;
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus random traffic, all
// compared against a queue-based reference model of the fetch PC and RAS.
module tb_pc_gen;

    localparam int          AW       = 16;
    localparam int          FW       = 2;
    localparam int          DEPTH    = 4;
    localparam logic [15:0] RST_PC   = 16'h0100;
    localparam logic [15:0] STEP     = 16'(4 * FW);
    localparam logic [15:0] ALIGN    = 16'hFFFC;

    logic          clk = 1'b0;
    logic          rst;
    logic          pc_stall;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic [AW-1:0] dec_pc;
    logic          dec_jump_valid;
    logic [AW-1:0] dec_jump_offset;
    logic          dec_call;
    logic          dec_ret;
    logic          br_redirect_valid;
    logic [AW-1:0] br_target;
    logic          ras_overflow;
    logic          ras_underflow;

    always #5 clk = ~clk;

    pc_gen #(
        .ADDR_WIDTH  (AW),
        .FETCH_WIDTH (FW),
        .RAS_DEPTH   (DEPTH),
        .RESET_PC    (RST_PC),
        .RAS_FLUSH   (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .pc_stall          (pc_stall),
        .pc                (pc),
        .pc_valid          (pc_valid),
        .dec_pc            (dec_pc),
        .dec_jump_valid    (dec_jump_valid),
        .dec_jump_offset   (dec_jump_offset),
        .dec_call          (dec_call),
        .dec_ret           (dec_ret),
        .br_redirect_valid (br_redirect_valid),
        .br_target         (br_target),
        .ras_overflow      (ras_overflow),
        .ras_underflow     (ras_underflow)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: the RAS is simply a list of return addresses.
    logic [AW-1:0] m_pc;
    logic          m_valid;
    logic          m_ovf;
    logic          m_unf;
    logic [AW-1:0] ras_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [AW-1:0] ret_tgt;
        logic          ret_hit;
        if (rst) begin
            m_pc    = RST_PC;
            m_valid = 1'b0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            ras_q.delete();
        end else begin
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            ret_hit = dec_ret && !br_redirect_valid && (ras_q.size() > 0);
            ret_tgt = ret_hit ? ras_q[$] : '0;
            if (br_redirect_valid) begin
                ras_q.delete();
            end else begin
                if (dec_ret) begin
                    if (ras_q.size() > 0) void'(ras_q.pop_back());
                    else m_unf = 1'b1;
                end
                if (dec_call) begin
                    ras_q.push_back(dec_pc + 16'd4);
                    if (ras_q.size() > DEPTH) begin
                        void'(ras_q.pop_front());
                        m_ovf = 1'b1;
                    end
                end
            end
            if (!m_valid)                m_valid = 1'b1;
            else if (br_redirect_valid)  m_pc = br_target & ALIGN;
            else if (dec_jump_valid)     m_pc = (dec_pc + dec_jump_offset) & ALIGN;
            else if (ret_hit)            m_pc = ret_tgt & ALIGN;
            else if (!pc_stall)          m_pc = m_pc + STEP;
        end
    endtask

    // One clock: update model, take the edge, compare all outputs just after it.
    task automatic step(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check({tag, ".pc"},    32'(pc),            32'(m_pc));
        check({tag, ".valid"}, 32'(pc_valid),      32'(m_valid));
        check({tag, ".ovf"},   32'(ras_overflow),  32'(m_ovf));
        check({tag, ".unf"},   32'(ras_underflow), 32'(m_unf));
    endtask

    task automatic drive(input logic b, input logic [15:0] bt, input logic j,
                         input logic [15:0] dp, input logic [15:0] off,
                         input logic c, input logic r, input logic s);
        br_redirect_valid = b;
        br_target         = bt;
        dec_jump_valid    = j;
        dec_pc            = dp;
        dec_jump_offset   = off;
        dec_call          = c;
        dec_ret           = r;
        pc_stall          = s;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    logic [15:0] exp_ret [4] = '{16'h0054, 16'h0044, 16'h0034, 16'h0024};

    initial begin
        rst = 1'b1;
        idle();
        #2;
        step("rst0");
        step("rst1");
        check("t1.rst_pc",    32'(pc),       32'h100);
        check("t1.rst_valid", 32'(pc_valid), 32'h0);

        // 1: release reset, reset vector first then sequential by 8 bytes
        rst = 1'b0;
        step("t1.a"); check("t1.pc_a", 32'(pc), 32'h100); check("t1.valid_a", 32'(pc_valid), 32'h1);
        step("t1.b"); check("t1.pc_b", 32'(pc), 32'h108);
        step("t1.c"); check("t1.pc_c", 32'(pc), 32'h110);

        // 2: branch beats jump and stall; stall holds; jump beats stall
        drive(1'b1, 16'h0800, 1'b1, 16'h0040, 16'h0020, 1'b0, 1'b0, 1'b1);
        step("t2.br"); check("t2.pc_br", 32'(pc), 32'h800);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
        step("t2.hold"); check("t2.pc_hold", 32'(pc), 32'h800);
        drive(1'b0, '0, 1'b1, 16'h0040, 16'h0020, 1'b0, 1'b0, 1'b1);
        step("t2.jmp"); check("t2.pc_jmp", 32'(pc), 32'h60);

        // 3: call/return, then return on an empty stack
        drive(1'b0, '0, 1'b0, 16'h0200, '0, 1'b1, 1'b0, 1'b0);
        step("t3.call");
        idle(); step("t3.gap");
        dec_ret = 1'b1;
        step("t3.ret"); check("t3.pc_ret", 32'(pc), 32'h204);
        step("t3.ret_empty"); check("t3.pc_seq", 32'(pc), 32'h20C); check("t3.unf", 32'(ras_underflow), 32'h1);
        idle(); step("t3.after"); check("t3.unf_clr", 32'(ras_underflow), 32'h0);

        // 4: five calls into a 4-deep stack, then unwind
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, '0, 1'b0, 16'(i * 16), '0, 1'b1, 1'b0, 1'b0);
            step("t4.call");
            check("t4.ovf", 32'(ras_overflow), (i == 5) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
            step("t4.ret");
            check("t4.pc_ret", 32'(pc), 32'(exp_ret[i]));
        end

        // Push and pop in one cycle: pop target is the old top, top replaced
        drive(1'b0, '0, 1'b0, 16'h0300, '0, 1'b1, 1'b0, 1'b0); step("tpp.call");
        drive(1'b0, '0, 1'b0, 16'h0400, '0, 1'b1, 1'b1, 1'b0); step("tpp.both");
        check("tpp.pc_old_top", 32'(pc), 32'h304);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); step("tpp.ret");
        check("tpp.pc_new_top", 32'(pc), 32'h404);

        // 5: redirect with a same-cycle return flushes the stack
        drive(1'b0, '0, 1'b0, 16'h0500, '0, 1'b1, 1'b0, 1'b0); step("t5.c1");
        drive(1'b0, '0, 1'b0, 16'h0600, '0, 1'b1, 1'b0, 1'b0); step("t5.c2");
        drive(1'b1, 16'h0900, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); step("t5.br");
        check("t5.pc_br", 32'(pc), 32'h900);
        drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b1, 1'b0); step("t5.ret");
        check("t5.unf", 32'(ras_underflow), 32'h1); check("t5.pc_seq", 32'(pc), 32'h908);

        // 6: wrap and alignment
        drive(1'b1, 16'hFFF8, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0); step("t6.br");
        idle(); step("t6.wrap"); check("t6.pc_wrap", 32'(pc), 32'h0000);
        drive(1'b1, 16'h1233, 1'b0, '0, '0, 1'b0, 1'b0, 1'b0); step("t6.align");
        check("t6.pc_align", 32'(pc), 32'h1230);
        drive(1'b0, '0, 1'b1, 16'hFFF0, 16'h0016, 1'b0, 1'b0, 1'b0); step("t6.jwrap");
        check("t6.pc_jwrap", 32'(pc), 32'h0004);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(63) == 0);
            drive($urandom_range(7) == 0, 16'($urandom), $urandom_range(5) == 0,
                  16'($urandom), 16'($urandom), $urandom_range(3) == 0,
                  $urandom_range(3) == 0, $urandom_range(2) == 0);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
